// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-128 inverse cipher.
//   - AES_NR / AES_BLK_W : round count and block width
//   - ST_*               : FSM state encodings (IDLE -> ROUND -> FINAL -> IDLE)
//   - xtime / gmul       : GF(2^8) arithmetic, reduction polynomial 0x11B
//   - inv_shift_rows     : InvShiftRows on the column-word state layout
// State layout: w0=[127:96] .. w3=[31:0]; byte [31:24] of each word is row 0.
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_BLK_W = 128;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;

  // Multiply by x in GF(2^8), reducing by 0x11B on overflow.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply by shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Row r of the state is rotated right by r columns.
  function automatic logic [AES_BLK_W-1:0] inv_shift_rows(input logic [AES_BLK_W-1:0] s);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] m0, m1, m2, m3;
    w0 = s[127:96];
    w1 = s[95:64];
    w2 = s[63:32];
    w3 = s[31:0];
    m0 = {w0[31:24], w3[23:16], w2[15:8], w1[7:0]};
    m1 = {w1[31:24], w0[23:16], w3[15:8], w2[7:0]};
    m2 = {w2[31:24], w1[23:16], w0[15:8], w3[7:0]};
    m3 = {w3[31:24], w2[23:16], w1[15:8], w0[7:0]};
    return {m0, m1, m2, m3};
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box, one byte, purely combinational.
// Ports:
//   din  : input byte (cipher-side value)
//   dout : InvSubBytes(din)
// Computed rather than tabulated: undo the affine transform, then take the
// multiplicative inverse in GF(2^8) as din'^254 (which maps 0 to 0).
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  logic [7:0] aff;
  logic [7:0] sq;
  logic [7:0] inv;

  // Inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05, then x^254 via repeated squaring.
  // Each pass squares sq (x^2, x^4 .. x^128) and folds it into the product,
  // so the product ends at x^(2+4+..+128) = x^254.
  always_comb begin
    aff = {din[6:0], din[7]} ^ {din[4:0], din[7:5]} ^ {din[1:0], din[7:2]} ^ 8'h05;
    inv = 8'h01;
    sq  = aff;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    dout = inv;
  end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher, one round per clock.
// A ciphertext block is accepted when i_start && o_ready; the plaintext
// appears on o_block with a one-cycle o_valid pulse 11 cycles later.
// Round keys are fetched from an external store: the core drives o_key_idx
// and expects the matching key on i_round_key in the same cycle.
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_start       : block request, i_block valid
//   i_block       : 128-bit ciphertext
//   o_ready       : idle, a block may be accepted this cycle
//   o_key_idx     : round-key index requested this cycle (10..0)
//   i_round_key   : round key for o_key_idx
//   o_block       : plaintext, held until the next completion
//   o_valid       : one-cycle pulse when o_block is updated
//   o_round       : round counter (only when AES_DEC_ROUND_OUT_EN is defined)
// Configuration macro: AES_DEC_ROUND_OUT_EN adds the o_round port; the
// datapath and timing are identical either way.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int NR    = AES_NR,
  parameter int IDX_W = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [AES_BLK_W-1:0] i_block,
  output logic                 o_ready,
  output logic [IDX_W-1:0]     o_key_idx,
  input  logic [AES_BLK_W-1:0] i_round_key,
  output logic [AES_BLK_W-1:0] o_block,
  output logic                 o_valid
`ifdef AES_DEC_ROUND_OUT_EN
  ,
  output logic [IDX_W-1:0]     o_round
`endif
);

  logic [1:0]           fsm;
  logic [IDX_W-1:0]     ctr;
  logic [AES_BLK_W-1:0] state_q;
  logic [AES_BLK_W-1:0] sr;
  logic [AES_BLK_W-1:0] sb;
  logic [AES_BLK_W-1:0] ark;
  logic [AES_BLK_W-1:0] imc;

  assign sr = inv_shift_rows(state_q);

  // Sixteen byte-parallel inverse S-boxes, shared by every round and FINAL.
  for (genvar g = 0; g < 16; g++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .din  (sr[8*g +: 8]),
      .dout (sb[8*g +: 8])
    );
  end

  assign ark = sb ^ i_round_key;

  // InvMixColumns on each column word; a0 is row 0 (the top byte of the word).
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    imc = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = ark[32*c+24 +: 8];
      a1 = ark[32*c+16 +: 8];
      a2 = ark[32*c+8  +: 8];
      a3 = ark[32*c    +: 8];
      imc[32*c+24 +: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      imc[32*c+16 +: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      imc[32*c+8  +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      imc[32*c    +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
  end

  // Key index: last round key while idle (the initial AddRoundKey happens on
  // the accept edge), the counter during ROUND, key 0 for the final round.
  always_comb begin
    o_key_idx = IDX_W'(NR);
    case (fsm)
      ST_ROUND: o_key_idx = ctr;
      ST_FINAL: o_key_idx = '0;
      default:  o_key_idx = IDX_W'(NR);
    endcase
  end

  assign o_ready = (fsm == ST_IDLE);

`ifdef AES_DEC_ROUND_OUT_EN
  // ctr already sits at 0 in FINAL, so only IDLE needs overriding.
  assign o_round = (fsm == ST_IDLE) ? IDX_W'(NR) : ctr;
`endif

  // Round sequencing. o_valid is a default-low pulse; i_start is only
  // looked at in IDLE, so requests while busy are simply dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fsm     <= ST_IDLE;
      ctr     <= '0;
      state_q <= '0;
      o_block <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (fsm)
        ST_IDLE: begin
          if (i_start) begin
            state_q <= i_block ^ i_round_key;
            ctr     <= IDX_W'(NR - 1);
            fsm     <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          state_q <= imc;
          ctr     <= ctr - 1'b1;
          if (ctr == IDX_W'(1)) fsm <= ST_FINAL;
        end
        ST_FINAL: begin
          o_block <= ark;
          o_valid <= 1'b1;
          fsm     <= ST_IDLE;
        end
        default: begin
          fsm <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
